// File: rtl/wb_bus_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// master indices and the round-robin tie-break.
package wb_arb_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_GNT0 = 2'd1;
  localparam logic [1:0] ARB_GNT1 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_GNT0 = ARB_GNT0,
    ST_GNT1 = ARB_GNT1
  } arb_state_t;

  localparam logic M_IFETCH = 1'b0;
  localparam logic M_DATA   = 1'b1;

  // On a tie the master that did not own the previous grant wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
    logic pick;
    if (req0 && req1) begin
      pick = (last_grant == M_DATA) ? M_IFETCH : M_DATA;
    end else if (req1) begin
      pick = M_DATA;
    end else begin
      pick = M_IFETCH;
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Signal bundle for the arbiter: both CPU-side Wishbone ports plus the shared
// downstream bus. The slave modport is the arbiter's view of it.
interface wb_bus_arbiter_if;

  logic        m0_cyc_i;
  logic        m0_stb_i;
  logic        m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i;
  logic [31:0] m0_dat_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m0_err_o;

  logic        m1_cyc_i;
  logic        m1_stb_i;
  logic        m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i;
  logic [31:0] m1_dat_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o;
  logic        m1_err_o;

  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        CYC_O;
  logic        STB_O;
  logic        ACK_I;
  logic [31:0] DAT_I;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O,
    input  ACK_I, DAT_I
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O,
    output ACK_I, DAT_I
  );

endinterface

// File: rtl/wb_bus_arbiter_watchdog.sv
// Per-transfer wait counter: cleared while the bus is idle, counts granted
// cycles without ACK and flags the last allowed cycle.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned  LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_INT);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // A zero timeout turns the watchdog off entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && en && (count_reg == LAST);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone classic arbiter (instruction fetch = m0, load/store = m1)
// with round-robin ties, grant held until ACK, and a per-transfer watchdog.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input logic             CLK_I,
  input logic             RST_I,
  wb_bus_arbiter_if.slave bus
);

  arb_state_t state_reg;
  arb_state_t state_next;
  logic       last_grant_reg;
  logic       last_grant_next;
  logic [1:0] err_reg;
  logic [1:0] err_next;

  logic [1:0] req;
  logic [1:0] cyc;
  logic [1:0] gnt;
  logic       owner_cyc;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;

  logic        slv_cyc;
  logic        slv_stb;
  logic        slv_we;
  logic [3:0]  slv_sel;
  logic [31:0] slv_adr;
  logic [31:0] slv_dat;

  assign req = {bus.m1_cyc_i & bus.m1_stb_i, bus.m0_cyc_i & bus.m0_stb_i};
  assign cyc = {bus.m1_cyc_i, bus.m0_cyc_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
    assign gnt[gi] = (state_reg == ((gi == 0) ? ST_GNT0 : ST_GNT1));
  end

  assign owner_cyc = |(gnt & cyc);
  assign wd_clr    = (state_reg == ST_IDLE);
  assign wd_en     = (|gnt) & ~bus.ACK_I;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  // Every grant returns to IDLE for one cycle, so the loser of a tie is
  // always reconsidered before the previous owner can win again.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    err_next        = '0;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          last_grant_next = rr_pick(req[0], req[1], last_grant_reg);
          state_next      = (last_grant_next == M_DATA) ? ST_GNT1 : ST_GNT0;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (bus.ACK_I || !owner_cyc) begin
          state_next = ST_IDLE;
        end else if (wd_expired) begin
          state_next = ST_IDLE;
          err_next   = gnt;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= M_DATA;
      err_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    slv_cyc = 1'b0;
    slv_stb = 1'b0;
    slv_we  = 1'b0;
    slv_sel = '0;
    slv_adr = '0;
    slv_dat = '0;
    if (gnt[0]) begin
      slv_cyc = bus.m0_cyc_i;
      slv_stb = bus.m0_stb_i;
      slv_we  = bus.m0_we_i;
      slv_sel = bus.m0_sel_i;
      slv_adr = bus.m0_adr_i;
      slv_dat = bus.m0_dat_i;
    end else if (gnt[1]) begin
      slv_cyc = bus.m1_cyc_i;
      slv_stb = bus.m1_stb_i;
      slv_we  = bus.m1_we_i;
      slv_sel = bus.m1_sel_i;
      slv_adr = bus.m1_adr_i;
      slv_dat = bus.m1_dat_i;
    end
  end

  assign bus.CYC_O = slv_cyc;
  assign bus.STB_O = slv_stb;
  assign bus.WE_O  = slv_we;
  assign bus.SEL_O = slv_sel;
  assign bus.ADR_O = slv_adr;
  assign bus.DAT_O = slv_dat;

  assign bus.m0_ack_o = gnt[0] & bus.ACK_I;
  assign bus.m1_ack_o = gnt[1] & bus.ACK_I;
  assign bus.m0_err_o = err_reg[0];
  assign bus.m1_err_o = err_reg[1];
  assign bus.m0_dat_o = bus.DAT_I;
  assign bus.m1_dat_o = bus.DAT_I;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Randomised scoreboard bench for wb_bus_arbiter: each round predicts grant
// order, slave-side fields and master responses from round-robin rules.
module tb_wb_bus_arbiter;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  wb_bus_arbiter_if bus ();

  wb_bus_arbiter #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (8)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .bus  (bus)
  );

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          exp_start;
    bit          chk_gap;
  } xfer_t;

  typedef struct {
    int          lat;     // -1: slave never acknowledges
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    int          m;
    bit          is_err;
    logic [31:0] rdata;
    int          off;
  } resp_t;

  xfer_t xq[$];
  plan_t pq[$];
  resp_t rq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int last_m   = 1;
  bit slave_en  = 1'b1;
  bit force_ack = 1'b0;

  logic [31:0] f_adr[2];
  logic [31:0] f_dat[2];
  logic [31:0] f_rdata[2];
  logic [3:0]  f_sel[2];
  logic        f_we[2];
  int          f_lat[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cycle);
  endtask

  task automatic randomize_fields();
    logic [31:0] t;
    for (int m = 0; m < 2; m++) begin
      t = $urandom;
      f_adr[m]   = {m[0], t[30:0]};
      f_dat[m]   = $urandom;
      f_rdata[m] = $urandom;
      t = $urandom;
      f_sel[m]   = t[3:0];
      f_we[m]    = t[4];
      f_lat[m]   = int'($urandom_range(0, 4));
      if (f_lat[m] == 4) f_lat[m] = -1;
    end
  endtask

  task automatic set_master(input int m, input bit on);
    if (m == 0) begin
      bus.m0_cyc_i = on; bus.m0_stb_i = on; bus.m0_we_i = f_we[0];
      bus.m0_sel_i = f_sel[0]; bus.m0_adr_i = f_adr[0]; bus.m0_dat_i = f_dat[0];
    end else begin
      bus.m1_cyc_i = on; bus.m1_stb_i = on; bus.m1_we_i = f_we[1];
      bus.m1_sel_i = f_sel[1]; bus.m1_adr_i = f_adr[1]; bus.m1_dat_i = f_dat[1];
    end
  endtask

  // Transaction-level model: a tie goes to the master that was not served last,
  // the loser follows after one idle cycle; a silent slave yields err T cycles in.
  task automatic run_round(input bit r0, input bit r1);
    int    order[$];
    int    budget;
    bit    pend[2];
    bit    drop_next[2];
    xfer_t x;
    plan_t p;
    resp_t r;
    @(negedge clk);
    if (r0 && r1) order = (last_m == 1) ? '{0, 1} : '{1, 0};
    else if (r0)  order = '{0};
    else          order = '{1};
    foreach (order[i]) begin
      x.m = order[i]; x.adr = f_adr[x.m]; x.dat = f_dat[x.m]; x.sel = f_sel[x.m];
      x.we = f_we[x.m]; x.exp_start = (i == 0) ? cycle + 1 : -1; x.chk_gap = (i != 0);
      xq.push_back(x);
      p.lat = f_lat[x.m]; p.rdata = f_rdata[x.m];
      pq.push_back(p);
      r.m = x.m; r.is_err = (f_lat[x.m] < 0); r.rdata = f_rdata[x.m];
      r.off = r.is_err ? T : f_lat[x.m];
      rq.push_back(r);
      last_m = x.m;
      $display("txn: m%0d adr=0x%08h we=%0b lat=%0d %s", x.m, x.adr, x.we, p.lat,
               r.is_err ? "expect err" : "expect ack");
    end
    pend[0] = r0; pend[1] = r1; drop_next[0] = 0; drop_next[1] = 0;
    set_master(0, r0);
    set_master(1, r1);
    budget = 60;
    while ((pend[0] || pend[1]) && budget > 0) begin
      #3;
      if (pend[0] && bus.m0_ack_o) drop_next[0] = 1;
      if (pend[1] && bus.m1_ack_o) drop_next[1] = 1;
      if (pend[0] && bus.m0_err_o) begin set_master(0, 0); pend[0] = 0; end
      if (pend[1] && bus.m1_err_o) begin set_master(1, 0); pend[1] = 0; end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (drop_next[m]) begin set_master(m, 0); pend[m] = 0; drop_next[m] = 0; end
      end
      budget--;
    end
    if (pend[0] || pend[1]) begin
      fail("round_timeout", "master never saw ack or err");
      set_master(0, 0);
      set_master(1, 0);
    end
  endtask

  // Slave model: acks the n-th cycle of each transfer as planned, else junk data.
  initial begin : slave
    bit    in_xfer;
    int    k;
    plan_t p;
    in_xfer = 0; k = 0; p.lat = -1; p.rdata = '0;
    bus.ACK_I = 1'b0;
    bus.DAT_I = '0;
    forever begin
      @(negedge clk);
      if (!slave_en) begin
        in_xfer   = 0;
        bus.ACK_I = force_ack;
      end else begin
        bus.ACK_I = 1'b0;
        bus.DAT_I = $urandom;
        if (bus.CYC_O && bus.STB_O) begin
          if (!in_xfer) begin
            in_xfer = 1; k = 0;
            if (pq.size() > 0) p = pq.pop_front();
            else begin p.lat = -1; p.rdata = '0; end
          end else begin
            k++;
          end
          if (k == p.lat) begin bus.ACK_I = 1'b1; bus.DAT_I = p.rdata; end
        end else begin
          in_xfer = 0;
        end
      end
    end
  end

  initial begin : monitor
    bit         prev_active;
    bit         active;
    int         cur_start;
    int         last_active;
    logic [1:0] acks;
    logic [1:0] errs;
    logic [1:0] exp_bits;
    xfer_t      x;
    resp_t      r;
    prev_active = 0; cur_start = 0; last_active = 0;
    forever begin
      @(negedge clk);
      #2;
      active = (bus.CYC_O === 1'b1) && (bus.STB_O === 1'b1);
      if (active && !prev_active) begin
        if (xq.size() == 0) begin
          fail("xfer_unexpected", $sformatf("bus started adr=0x%08h", bus.ADR_O));
        end else begin
          x = xq.pop_front();
          chk($sformatf("adr_o(m%0d)", x.m), bus.ADR_O, x.adr);
          chk($sformatf("dat_o(m%0d)", x.m), bus.DAT_O, x.dat);
          chk($sformatf("sel_o(m%0d)", x.m), 32'(bus.SEL_O), 32'(x.sel));
          chk($sformatf("we_o(m%0d)", x.m), 32'(bus.WE_O), 32'(x.we));
          if (x.exp_start >= 0) chk("grant_cycle", 32'(cycle), 32'(x.exp_start));
          if (x.chk_gap) chk("idle_gap", 32'(cycle - last_active), 32'd2);
        end
        cur_start = cycle;
      end
      if (active) last_active = cycle;
      prev_active = active;
      acks = {bus.m1_ack_o, bus.m0_ack_o};
      errs = {bus.m1_err_o, bus.m0_err_o};
      if (acks != 2'b00 || errs != 2'b00) begin
        if (rq.size() == 0) begin
          fail("resp_unexpected", $sformatf("ack=%b err=%b", acks, errs));
        end else begin
          r = rq.pop_front();
          exp_bits = 2'b01 << r.m;
          chk($sformatf("ack_o(m%0d)", r.m), 32'(acks), r.is_err ? 32'd0 : 32'(exp_bits));
          chk($sformatf("err_o(m%0d)", r.m), 32'(errs), r.is_err ? 32'(exp_bits) : 32'd0);
          chk($sformatf("resp_cycle(m%0d)", r.m), 32'(cycle - cur_start), 32'(r.off));
          if (!r.is_err) begin
            chk("m0_dat_o", bus.m0_dat_o, r.rdata);
            chk("m1_dat_o", bus.m1_dat_o, r.rdata);
          end
        end
      end
    end
  end

  initial begin : stim
    xfer_t x;
    int    v;
    rst = 1'b1;
    randomize_fields();
    set_master(0, 1);
    set_master(1, 1);
    repeat (3) @(negedge clk);
    #3;
    chk("reset_cyc_o", 32'(bus.CYC_O), 32'd0);
    chk("reset_stb_o", 32'(bus.STB_O), 32'd0);
    chk("reset_adr_o", bus.ADR_O, 32'd0);
    chk("reset_err_o", 32'({bus.m1_err_o, bus.m0_err_o}), 32'd0);
    @(negedge clk);
    set_master(0, 0);
    set_master(1, 0);
    rst = 1'b0;
    last_m = 1;

    // m1 alone, zero-wait read
    randomize_fields();
    f_adr[1] = 32'h0000_1000; f_we[1] = 1'b0; f_lat[1] = 0; f_rdata[1] = 32'hDEAD_BEEF;
    run_round(0, 1);
    // ties with zero-wait slave alternate
    for (int i = 0; i < 2; i++) begin
      randomize_fields(); f_lat[0] = 0; f_lat[1] = 0;
      run_round(1, 1);
    end
    // m0 holds through wait states while m1 waits
    randomize_fields(); f_lat[0] = 3; f_lat[1] = 0;
    run_round(1, 1);
    // m1 write times out, then m0 gets the bus
    randomize_fields(); f_lat[1] = -1; f_we[1] = 1'b1;
    run_round(0, 1);
    randomize_fields(); f_lat[0] = 1;
    run_round(1, 0);
    // ack on the expiry cycle
    randomize_fields(); f_lat[1] = T - 1;
    run_round(0, 1);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      randomize_fields();
      v = int'($urandom_range(1, 3));
      run_round(v[0], v[1]);
    end

    // reset in the middle of an m0 transfer with a silent slave
    randomize_fields();
    slave_en = 0; force_ack = 0;
    @(negedge clk);
    x.m = 0; x.adr = f_adr[0]; x.dat = f_dat[0]; x.sel = f_sel[0]; x.we = f_we[0];
    x.exp_start = cycle + 1; x.chk_gap = 0;
    xq.push_back(x);
    set_master(0, 1);
    $display("txn: m0 adr=0x%08h reset mid-transfer", f_adr[0]);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #3 force_ack = 1;
    @(negedge clk);
    #3;
    chk("rst_mid_cyc_o", 32'(bus.CYC_O), 32'd0);
    chk("rst_mid_stb_o", 32'(bus.STB_O), 32'd0);
    chk("rst_mid_adr_o", bus.ADR_O, 32'd0);
    chk("rst_mid_m0_ack_o", 32'(bus.m0_ack_o), 32'd0);
    rst = 1'b0;
    set_master(0, 0);
    force_ack = 0;
    slave_en = 1;
    last_m = 1;
    randomize_fields();
    run_round(1, 1);

    repeat (6) @(negedge clk);
    chk("xfer_queue_drained", 32'(xq.size()), 32'd0);
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("plan_queue_drained", 32'(pq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master / one-slave Wishbone B4 (classic, single-transfer) arbiter between the CPU instruction-fetch port (m0) and the load/store bus port (m1).
- Its single downstream port drives the shared RAM/device bus.
- Round-robin grant with lock-until-ACK.
- A per-transfer watchdog returns an error pulse to the owning master when the slave never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted transfer may wait for ACK_I before abort; 0 disables the watchdog.
- CNT_W, 8: watchdog counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- CLK_I  in  1  system clock, all logic on rising edge
- RST_I  in  1  synchronous, active-high reset
- m0_cyc_i / m1_cyc_i  in  1 each  master cycle request
- m0_stb_i / m1_stb_i  in  1 each  master strobe
- m0_we_i / m1_we_i  in  1 each  master write enable
- m0_sel_i / m1_sel_i  in  4 each  master byte selects
- m0_adr_i / m1_adr_i  in  32 each  master address
- m0_dat_i / m1_dat_i  in  32 each  master write data
- m0_dat_o / m1_dat_o  out  32 each  read data, both = DAT_I
- m0_ack_o / m1_ack_o  out  1 each  acknowledge routed to granted master
- m0_err_o / m1_err_o  out  1 each  watchdog abort pulse
- ADR_O  out  32  slave address
- DAT_O  out  32  slave write data
- SEL_O  out  4  slave byte selects
- WE_O  out  1  slave write enable
- CYC_O  out  1  slave cycle
- STB_O  out  1  slave strobe
- ACK_I  in  1  slave acknowledge
- DAT_I  in  32  slave read data

Behaviour:
- State machine, registered: IDLE, GNT0, GNT1. Request mX = mX_cyc_i & mX_stb_i.
- IDLE transitions:
  - Only m0 requesting -> GNT0; only m1 requesting -> GNT1.
  - Both requesting -> grant the master that is not last_grant, then update last_grant.
  - No request -> stay in IDLE.
- GNTx transitions:
  - ACK_I=1 -> IDLE (always release; arbitration costs one idle cycle between transfers, which gives fairness).
  - mX_cyc_i=0 (master abort) -> IDLE.
  - Watchdog expiry -> IDLE.
- Slave outputs, combinational mux of the granted master's signals:
  - CYC_O = mX_cyc_i, STB_O = mX_stb_i; ADR_O, DAT_O, SEL_O, WE_O passed through.
  - In IDLE: CYC_O, STB_O, WE_O = 0; SEL_O = 0; ADR_O, DAT_O = 0.
- Ack routing: mX_ack_o = (state==GNTx) & ACK_I, combinational. ACK_I in IDLE is ignored and not forwarded.
- Latency: request seen at edge n gives grant state from cycle n+1; a zero-wait slave acks in cycle n+1; the next grant is no earlier than cycle n+3.
- Watchdog:
  - Counter cleared on entry to GNTx and incremented each GNTx cycle without ACK_I.
  - When count == TIMEOUT_CYCLES-1 without ACK_I: register mX_err_o=1 for exactly one cycle (the IDLE cycle that follows) and go to IDLE.
- Simultaneous events:
  - ACK_I and expiry in the same cycle -> ACK wins, no err.
  - Abort and ACK in the same cycle -> ack is still forwarded.
- Reset, including mid-transfer: state=IDLE, last_grant=1 (m0 wins the first tie), counter=0, err outputs 0. All slave outputs go low from the next cycle.
- Grant never changes while in GNTx, whatever the other master does.

Decomposition:
- Shared package wb_arb_pkg:
  - state encoding localparams ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2.
  - master index constants M_IFETCH=0, M_DATA=1.
- One sub-module, wb_arb_watchdog: counter with clear, enable and expiry output, parameterised by TIMEOUT_CYCLES and CNT_W.

Test Plan:
- m1 only, read at adr 0x0000_1000, slave acks on first grant cycle with DAT_I=0xDEAD_BEEF -> CYC_O/STB_O high one cycle, ADR_O=0x1000, m1_ack_o=1, m1_dat_o=0xDEADBEEF, m0_ack_o=0.
- m0 and m1 both request out of reset, continuous single-cycle acks -> grants alternate m0, m1, m0, m1 with one idle cycle between each.
- m0 holds grant with slave wait-states of 3 cycles while m1 requests -> m1 waits; grant moves to m1 only after m0_ack_o.
- TIMEOUT_CYCLES=4, m1 write with no ACK_I -> CYC_O high 4 cycles, then m1_err_o pulses for 1 cycle, arbiter in IDLE, and an m0 request is granted afterwards.
- ACK_I on the exact expiry cycle -> ack forwarded, no err.
- RST_I asserted during GNT0 -> next cycle CYC_O=0, m0_ack_o=0; a subsequent tie is granted to m0.
